// File: rtl/jtag_instr_reg_if.sv
// ---------------------------------------------------------------------------
// jtag_instr_reg_if
// Connection bundle between the TAP controller side and the instruction
// register stage.
//   tap_reset, ir_capture, ir_shift, ir_update : IR strobes from the TAP FSM
//   TDI                                       : serial data in
//   ir_tdo                                    : serial data out (sr[0])
//   instr                                     : active instruction
//   sel_extest/idcode/sample/debug/bypass     : one-hot DR select lines
// master = TAP controller side, slave = instruction register stage.
// ---------------------------------------------------------------------------
interface jtag_instr_reg_if #(
   parameter int IR_WIDTH = 5
);
   logic                tap_reset;
   logic                ir_capture;
   logic                ir_shift;
   logic                ir_update;
   logic                TDI;
   logic                ir_tdo;
   logic [IR_WIDTH-1:0] instr;
   logic                sel_extest;
   logic                sel_idcode;
   logic                sel_sample;
   logic                sel_debug;
   logic                sel_bypass;

   modport master (
      output tap_reset, ir_capture, ir_shift, ir_update, TDI,
      input  ir_tdo, instr, sel_extest, sel_idcode, sel_sample, sel_debug, sel_bypass
   );

   modport slave (
      input  tap_reset, ir_capture, ir_shift, ir_update, TDI,
      output ir_tdo, instr, sel_extest, sel_idcode, sel_sample, sel_debug, sel_bypass
   );
endinterface

// File: rtl/jtag_instr_reg.sv
// ---------------------------------------------------------------------------
// jtag_instr_reg
// JTAG instruction register stage downstream of the TAP controller. Captures
// and shifts the instruction between TDI and ir_tdo, commits it to instr on
// update, and decodes instr into one-hot DR select lines (unknown -> BYPASS).
//   TCK  : clock, all state changes on the rising edge
//   TRST : synchronous active-high reset
//   bus  : jtag_instr_reg_if slave modport (strobes, TDI, ir_tdo, instr, sel_*)
// ---------------------------------------------------------------------------
module jtag_instr_reg #(
   parameter int                  IR_WIDTH    = 5,
   parameter logic [IR_WIDTH-1:0] CAPTURE_VAL = IR_WIDTH'(1),
   parameter logic [IR_WIDTH-1:0] OP_EXTEST   = IR_WIDTH'(0),
   parameter logic [IR_WIDTH-1:0] OP_IDCODE   = IR_WIDTH'(1),
   parameter logic [IR_WIDTH-1:0] OP_SAMPLE   = IR_WIDTH'(2),
   parameter logic [IR_WIDTH-1:0] OP_DEBUG    = IR_WIDTH'(8),
   parameter logic [IR_WIDTH-1:0] OP_BYPASS   = '1
) (
   input logic              TCK,
   input logic              TRST,
   jtag_instr_reg_if.slave  bus
);

   logic [IR_WIDTH-1:0] sr;
   logic [IR_WIDTH-1:0] instr_q;
   logic                rst_any;

   assign rst_any = TRST | bus.tap_reset;

   // Shift register: reset > capture > shift > hold.
   // NOTE: sequential state uses <= so every register samples pre-edge values;
   // instr below relies on reading the old sr in the same edge.
   always_ff @(posedge TCK) begin
      if (rst_any) begin
         sr <= CAPTURE_VAL;
      end else if (bus.ir_capture) begin
         sr <= CAPTURE_VAL;
      end else if (bus.ir_shift) begin
         sr <= {bus.TDI, sr[IR_WIDTH-1:1]};
      end
   end

   // Active instruction: update is ignored if it overlaps capture or shift,
   // so instr can never move while a scan is in progress.
   always_ff @(posedge TCK) begin
      if (rst_any) begin
         instr_q <= OP_IDCODE;
      end else if (bus.ir_update && !bus.ir_capture && !bus.ir_shift) begin
         instr_q <= sr;
      end
   end

   assign bus.ir_tdo = sr[0];
   assign bus.instr  = instr_q;

   // Decode from the registered instruction only, so selects never glitch
   // during a scan. Anything not recognised falls through to BYPASS.
   always_comb begin
      // NOTE: every output gets a default first so no latch is inferred.
      bus.sel_extest = 1'b0;
      bus.sel_idcode = 1'b0;
      bus.sel_sample = 1'b0;
      bus.sel_debug  = 1'b0;
      bus.sel_bypass = 1'b0;
      if (instr_q == OP_EXTEST) begin
         bus.sel_extest = 1'b1;
      end else if (instr_q == OP_IDCODE) begin
         bus.sel_idcode = 1'b1;
      end else if (instr_q == OP_SAMPLE) begin
         bus.sel_sample = 1'b1;
      end else if (instr_q == OP_DEBUG) begin
         bus.sel_debug = 1'b1;
      end else begin
         bus.sel_bypass = 1'b1;
      end
   end

endmodule
